layernorm_result_streamer: RTL
==============================

// Module: layernorm_result_streamer
// PURPOSE
//  Drain side of the layernorm result interface: captures the full-frame result bus when result_valid_n pulses low,
//  then streams it out as LANES-element beats over a valid/ready handshake, row 0 first, toward the writeback/DMA path.
//  Replaces direct wiring of the SENTENCE_NUM*INPUT_NUM result bus into downstream logic.
// PARAMETERS
//  OUTPUT_WIDTH  8    bits per result element
//  SENTENCE_NUM  128  rows per frame
//  INPUT_NUM     768  elements per row; must be a multiple of LANES
//  LANES         16   elements per output beat; BEATS_PER_ROW = INPUT_NUM/LANES
// PORTS
//  clk_p           in   1                                    clock, rising edge
//  rst_n           in   1                                    async reset, active low
//  result          in   OUTPUT_WIDTH*SENTENCE_NUM*INPUT_NUM  frame from layernorm; element e of row r at bits [(r*INPUT_NUM+e)*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//  result_valid_n  in   1                                    active-low, one-cycle frame strobe
//  out_data        out  OUTPUT_WIDTH*LANES                   beat payload; lane k = element beat*LANES+k
//  out_valid       out  1                                    beat valid
//  out_ready       in   1                                    downstream accepts beat
//  busy            out  1                                    frame held / streaming
//  done_n          out  1                                    active-low one-cycle pulse after last beat accepted
//  ovf             out  1                                    sticky: strobe arrived while busy and not accepted
//  ovf_clr         in   1                                    synchronous clear of ovf
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; out_valid=0, out_data=0, busy=0, done_n=1, ovf=0; row/beat counters 0.
//  States: IDLE, STREAM.
//  IDLE: result_valid_n=0 -> capture result into frame register, row=beat=0, go STREAM. Else stay.
//  STREAM: out_valid=1, busy=1; out_data = frame slice for (row,beat), registered, stable while out_valid & !out_ready.
//   Transfer = out_valid & out_ready. On transfer: beat++; beat wraps at BEATS_PER_ROW-1 -> 0 with row++.
//   Last transfer (row=SENTENCE_NUM-1, beat=BEATS_PER_ROW-1): done_n=0 next cycle; return to IDLE,
//   unless result_valid_n=0 in that same cycle -> capture new frame, stay STREAM, counters 0 (back-to-back, no bubble).
//  Latency: strobe in cycle N -> first beat out_valid=1 in cycle N+1; frame takes SENTENCE_NUM*BEATS_PER_ROW transfers minimum.
//  result_valid_n=0 in STREAM other than on last transfer: ignored, frame register untouched, ovf<=1.
//  ovf_clr and new overflow same cycle: ovf=1 (set wins).
//  out_ready high with out_valid low: no effect. Input held low >1 cycle: each low cycle is treated as a strobe.
//  Reset mid-frame: streaming aborts immediately, no done_n pulse, remaining beats discarded.
//  Counters sized $clog2 of bounds (min 1 bit); no wrap beyond bounds possible.
// CONFIGURATION
//  LNRS_LAST_EN defined: adds outputs out_row_last (1 on beat BEATS_PER_ROW-1) and out_frame_last
//   (1 on final beat of frame), both qualified by out_valid, reset 0.
//  Not defined: ports absent; all other behaviour identical.
// STRUCTURE
//  Package layernorm_stream_pkg: state enum {IDLE,STREAM}, localparam functions for BEATS_PER_ROW,
//   ROW_W, BEAT_W, BEAT_BITS, ROW_BITS.
//  One sub-module ln_row_beat_cnt: nested row/beat counter with clr, inc, last_beat, last_frame outputs.
//  Frame register and beat mux stay in the top module.
// TESTING (SENTENCE_NUM=2, INPUT_NUM=4, LANES=2, OUTPUT_WIDTH=8 -> 4 beats; element i = 8'h10+i)
//  Strobe, out_ready=1 always -> beats 16'h1110,16'h1312,16'h1514,16'h1716 in cycles N+1..N+4; done_n=0 at N+5.
//  out_ready toggling 1,0,0,1... -> out_data held stable across stall cycles; same 4 beats, no drop/duplicate.
//  Second strobe during beat 1 -> ovf=1, beats continue from first frame unchanged; ovf_clr -> ovf=0.
//  Second strobe (elements 8'h20+i) coincident with last transfer -> next cycle beat 16'h2120, no idle cycle, ovf=0.
//  rst_n=0 after beat 2 -> out_valid=0, busy=0 immediately, no done_n; fresh strobe restarts at beat 0.
//  LNRS_LAST_EN build: out_row_last=1 on beats 1 and 3, out_frame_last=1 on beat 3 only.

Source files
------------

// File: rtl/layernorm_stream_pkg.sv
// Shared types and sizing helpers for the layernorm result streamer.
// The state enum and the width/size functions below are imported by the
// streamer top and its row/beat counter.
package layernorm_stream_pkg;

    // Streamer control state. IDLE waits for a frame strobe. STREAM presents beats.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Counter width for a count bound. It is at least 1 bit, so a bound of 1 still gets a real register.
    function automatic int cnt_width(input int bound);
        return (bound <= 1) ? 1 : $clog2(bound);
    endfunction

    // Number of output beats needed to carry one row of INPUT_NUM elements.
    function automatic int beats_per_row(input int input_num, input int lanes);
        return input_num / lanes;
    endfunction

    // Width of the row counter.
    function automatic int row_w(input int sentence_num);
        return cnt_width(sentence_num);
    endfunction

    // Width of the beat-within-row counter.
    function automatic int beat_w(input int input_num, input int lanes);
        return cnt_width(beats_per_row(input_num, lanes));
    endfunction

    // Payload bits in one beat.
    function automatic int beat_bits(input int output_width, input int lanes);
        return output_width * lanes;
    endfunction

    // Bits in one full row of results.
    function automatic int row_bits(input int output_width, input int input_num);
        return output_width * input_num;
    endfunction

endpackage

// File: rtl/ln_row_beat_cnt.sv
// Nested row/beat position counter for the layernorm result streamer.
// The beat counter runs 0..BEATS-1. When it wraps, the row counter advances.
// The row counter wraps to 0 after the last beat of the last row.
// clr has priority over inc.
module ln_row_beat_cnt
    import layernorm_stream_pkg::*;
#(
    parameter int ROWS   = 128,
    parameter int BEATS  = 48,
    parameter int ROW_W  = 7,
    parameter int BEAT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ROW_W-1:0]  row,
    output logic [BEAT_W-1:0] beat,
    output logic              last_beat,
    output logic              last_frame
);

    // Terminal-count decodes used by the counter itself and by the streamer FSM.
    always_comb begin
        last_beat  = (beat == BEAT_W'(BEATS - 1));
        last_frame = last_beat && (row == ROW_W'(ROWS - 1));
    end

    // Position register: clear on frame capture, otherwise step once per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            beat <= '0;
        end else if (clr) begin
            row  <= '0;
            beat <= '0;
        end else if (inc) begin
            if (last_beat) begin
                beat <= '0;
                row  <= last_frame ? '0 : row + 1'b1;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/layernorm_result_streamer.sv
// Drain side of the layernorm result interface.
// It latches the whole result frame on an active-low strobe. It then replays the
// frame as LANES-element beats, row 0 first, beat 0 first within each row.
// Optional feature macro: LNRS_LAST_EN adds the out_row_last / out_frame_last
// markers. When the macro is undefined those ports do not exist.
//
// Output handshake: a beat moves when out_valid and out_ready are both high on
// a rising clk_p edge. Once out_valid is high, out_data (and the last markers)
// stay constant until that transfer happens. out_valid never drops without a
// transfer, except on reset. out_ready has no effect while out_valid is low.
module layernorm_result_streamer
    import layernorm_stream_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 8,
    parameter int SENTENCE_NUM = 128,
    parameter int INPUT_NUM    = 768,
    parameter int LANES        = 16
) (
    input  logic                                       clk_p,
    input  logic                                       rst_n,
    input  logic [OUTPUT_WIDTH*SENTENCE_NUM*INPUT_NUM-1:0] result,
    input  logic                                       result_valid_n,
    output logic [OUTPUT_WIDTH*LANES-1:0]              out_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       busy,
    output logic                                       done_n,
`ifdef LNRS_LAST_EN
    output logic                                       out_row_last,
    output logic                                       out_frame_last,
`endif
    input  logic                                       ovf_clr,
    output logic                                       ovf
);

    localparam int BPR         = beats_per_row(INPUT_NUM, LANES);
    localparam int TOTAL_BEATS = SENTENCE_NUM * BPR;
    localparam int ROW_W       = row_w(SENTENCE_NUM);
    localparam int BEAT_W      = beat_w(INPUT_NUM, LANES);
    localparam int BEAT_BITS   = beat_bits(OUTPUT_WIDTH, LANES);
    localparam int IDX_W       = cnt_width(TOTAL_BEATS);

    // The frame is stored beat-major. In the flat layout, beat g of the frame is
    // exactly bits [g*BEAT_BITS +: BEAT_BITS], because each row is a whole number of beats.
    logic [TOTAL_BEATS-1:0][BEAT_BITS-1:0] frame_q;

    state_e              state;
    logic                strobe;
    logic                xfer;
    logic                capture;
    logic [ROW_W-1:0]    row;
    logic [BEAT_W-1:0]   beat;
    logic                last_beat;
    logic                last_frame;
    logic [ROW_W-1:0]    nxt_row;
    logic [BEAT_W-1:0]   nxt_beat;
    logic [IDX_W-1:0]    nxt_idx;
`ifdef LNRS_LAST_EN
    logic                nxt_row_last;
    logic                nxt_frame_last;
`endif

    // Handshake decode and position of the beat presented after the current transfer.
    always_comb begin
        strobe   = !result_valid_n;
        xfer     = out_valid & out_ready;
        // A strobe is taken when idle. It is also taken when the final beat of the
        // current frame is accepted in the same cycle, so back-to-back frames have no bubble.
        capture  = strobe & ((state == IDLE) | (xfer & last_frame));
        nxt_beat = last_beat ? '0 : beat + 1'b1;
        nxt_row  = last_beat ? row + 1'b1 : row;
        nxt_idx  = IDX_W'(nxt_row) * IDX_W'(BPR) + IDX_W'(nxt_beat);
`ifdef LNRS_LAST_EN
        nxt_row_last   = (nxt_beat == BEAT_W'(BPR - 1));
        nxt_frame_last = nxt_row_last && (nxt_row == ROW_W'(SENTENCE_NUM - 1));
`endif
    end

    // Row/beat position of the beat currently held in out_data.
    ln_row_beat_cnt #(
        .ROWS   (SENTENCE_NUM),
        .BEATS  (BPR),
        .ROW_W  (ROW_W),
        .BEAT_W (BEAT_W)
    ) u_cnt (
        .clk        (clk_p),
        .rst_n      (rst_n),
        .clr        (capture),
        .inc        (xfer),
        .row        (row),
        .beat       (beat),
        .last_beat  (last_beat),
        .last_frame (last_frame)
    );

    // Frame holding register: loaded only on an accepted strobe. Ignored strobes leave it untouched.
    always_ff @(posedge clk_p) begin
        if (capture) begin
            frame_q <= result;
        end
    end

    // Control FSM with registered beat payload, status and completion pulse.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done_n    <= 1'b1;
            ovf       <= 1'b0;
`ifdef LNRS_LAST_EN
            out_row_last   <= 1'b0;
            out_frame_last <= 1'b0;
`endif
        end else begin
            done_n <= 1'b1;

            if (capture) begin
                // Beat 0 comes straight from the bus because frame_q is loading in this same cycle.
                state     <= STREAM;
                out_valid <= 1'b1;
                busy      <= 1'b1;
                out_data  <= result[BEAT_BITS-1:0];
`ifdef LNRS_LAST_EN
                out_row_last   <= (BPR == 1);
                out_frame_last <= (TOTAL_BEATS == 1);
`endif
            end else if (state == STREAM && xfer) begin
                if (last_frame) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    out_data  <= '0;
`ifdef LNRS_LAST_EN
                    out_row_last   <= 1'b0;
                    out_frame_last <= 1'b0;
`endif
                end else begin
                    out_data <= frame_q[nxt_idx];
`ifdef LNRS_LAST_EN
                    out_row_last   <= nxt_row_last;
                    out_frame_last <= nxt_frame_last;
`endif
                end
            end

            // Completion pulse fires even when a new frame is captured in the same cycle.
            if (state == STREAM && xfer && last_frame) begin
                done_n <= 1'b0;
            end

            // The sticky overflow flag is set after the clear, so a new overflow wins over ovf_clr.
            if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (state == STREAM && strobe && !capture) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
